lc3_int_ctrl: RTL and testbench

LC3_INT_CTRL -- requirements
Module: lc3_int_ctrl

---
 rtl/lc3_pkg.sv | 15 +
 rtl/lc3_prio_arbiter.sv | 28 ++
 rtl/lc3_int_ctrl.sv | 146 ++++++++++++++
 tb/tb_lc3_int_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 interrupt controller.
package lc3_pkg;

    localparam int unsigned PRIO_W       = 3;
    localparam int unsigned VEC_W        = 8;
    localparam int unsigned IDX_W        = 4;
    localparam logic [VEC_W-1:0] VEC_BASE_DEF = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } state_e;

endpackage

// File: rtl/lc3_prio_arbiter.sv
// Picks the highest-priority eligible source; ties go to the lowest index.
module lc3_prio_arbiter
    import lc3_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]        elig_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    output logic                      valid_o,
    output logic [IDX_W-1:0]          idx_o,
    output logic [PRIO_W-1:0]         prio_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        prio_o  = '0;
        // Strict '>' while scanning upwards keeps the lowest index on a tie.
        for (int k = 0; k < NUM_SRC; k++) begin
            if (elig_i[k] && (!valid_o || (prio_i[k*PRIO_W +: PRIO_W] > prio_o))) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
                prio_o  = prio_i[k*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt controller: per-source level/edge capture, priority arbitration
// and a registered request/acknowledge handshake towards the control FSM.
module lc3_int_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned        NUM_SRC  = 4,
    parameter logic [VEC_W-1:0]   VEC_BASE = VEC_BASE_DEF,
    parameter logic [NUM_SRC-1:0] EDGE_RST = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_idx,
    input  logic               cfg_en,
    input  logic               cfg_edge,
    input  logic [2:0]         cfg_prio,
    input  logic [2:0]         cur_prio,
    input  logic               int_ack,
    output logic               int_req,
    output logic [2:0]         int_prio,
    output logic [7:0]         int_vec,
    output logic [NUM_SRC-1:0] pending
);

    state_e state_q, state_d;

    logic [NUM_SRC-1:0]             en_q, en_d;
    logic [NUM_SRC-1:0]             edge_mode_q, edge_mode_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0]             irq_prev_q;
    logic [NUM_SRC-1:0]             edge_pend_q, edge_pend_d;
    logic [IDX_W-1:0]               win_idx_q, win_idx_d;
    logic [PRIO_W-1:0]              int_prio_q, int_prio_d;
    logic [VEC_W-1:0]               int_vec_q, int_vec_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] ack_clr;
    logic               win_elig;
    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [PRIO_W-1:0]  arb_prio;

    always_comb begin
        pending  = '0;
        eligible = '0;
        win_elig = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pending[k]  = rst & (edge_mode_q[k] ? edge_pend_q[k] : irq[k]);
            eligible[k] = pending[k] & en_q[k] & (prio_q[k] > cur_prio);
            if (win_idx_q == IDX_W'(k)) begin
                win_elig = eligible[k];
            end
        end
    end

    lc3_prio_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .elig_i  (eligible),
        .prio_i  (prio_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx),
        .prio_o  (arb_prio)
    );

    always_comb begin
        state_d    = state_q;
        win_idx_d  = win_idx_q;
        int_prio_d = int_prio_q;
        int_vec_d  = int_vec_q;
        ack_clr    = '0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d    = StReq;
                    win_idx_d  = arb_idx;
                    int_prio_d = arb_prio;
                    int_vec_d  = VEC_BASE + VEC_W'(arb_idx);
                end
            end
            StReq: begin
                // Ack takes precedence over a simultaneous loss of eligibility.
                if (int_ack) begin
                    state_d = StHold;
                    for (int k = 0; k < NUM_SRC; k++) begin
                        ack_clr[k] = (win_idx_q == IDX_W'(k));
                    end
                end else if (!win_elig) begin
                    state_d = StIdle;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en_d        = en_q;
        edge_mode_d = edge_mode_q;
        prio_d      = prio_q;
        // A fresh rising edge beats the ack-clear of the same source.
        edge_pend_d = edge_mode_q & ((edge_pend_q & ~ack_clr) | (irq & ~irq_prev_q));
        if (cfg_we) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (cfg_idx == IDX_W'(k)) begin
                    en_d[k]        = cfg_en;
                    edge_mode_d[k] = cfg_edge;
                    prio_d[k]      = cfg_prio;
                    if (!cfg_edge) begin
                        edge_pend_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            en_q        <= '0;
            edge_mode_q <= EDGE_RST;
            prio_q      <= '0;
            irq_prev_q  <= '0;
            edge_pend_q <= '0;
            win_idx_q   <= '0;
            int_prio_q  <= '0;
            int_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            edge_mode_q <= edge_mode_d;
            prio_q      <= prio_d;
            irq_prev_q  <= irq;
            edge_pend_q <= edge_pend_d;
            win_idx_q   <= win_idx_d;
            int_prio_q  <= int_prio_d;
            int_vec_q   <= int_vec_d;
        end
    end

    assign int_req  = (state_q == StReq);
    assign int_prio = int_prio_q;
    assign int_vec  = int_vec_q;

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Self-checking bench for lc3_int_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_lc3_int_ctrl;

    localparam int NS = 4;
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_HOLD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] irq = '0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_idx = '0;
    logic          cfg_en = 1'b0;
    logic          cfg_edge = 1'b0;
    logic [2:0]    cfg_prio = '0;
    logic [2:0]    cur_prio = '0;
    logic          int_ack = 1'b0;
    logic          int_req;
    logic [2:0]    int_prio;
    logic [7:0]    int_vec;
    logic [NS-1:0] pending;

    lc3_int_ctrl #(
        .NUM_SRC  (NS),
        .VEC_BASE (8'h80),
        .EDGE_RST (4'b1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_en   (cfg_en),
        .cfg_edge (cfg_edge),
        .cfg_prio (cfg_prio),
        .cur_prio (cur_prio),
        .int_ack  (int_ack),
        .int_req  (int_req),
        .int_prio (int_prio),
        .int_vec  (int_vec),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int            m_state;
    int            m_win;
    logic [2:0]    m_wprio;
    logic [7:0]    m_vec;
    logic [NS-1:0] m_en, m_edge, m_latch, m_prev;
    logic [2:0]    m_prio [NS];

    function automatic logic [NS-1:0] m_pending();
        logic [NS-1:0] p;
        for (int k = 0; k < NS; k++) p[k] = m_edge[k] ? m_latch[k] : irq[k];
        return p;
    endfunction

    function automatic logic [NS-1:0] m_elig();
        logic [NS-1:0] p, e;
        p = m_pending();
        for (int k = 0; k < NS; k++) e[k] = p[k] && m_en[k] && (m_prio[k] > cur_prio);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_win   = 0;
        m_wprio = '0;
        m_vec   = '0;
        m_en    = '0;
        m_edge  = 4'b1000;
        m_latch = '0;
        m_prev  = '0;
        for (int k = 0; k < NS; k++) m_prio[k] = '0;
    endtask

    task automatic check_model();
        chk("int_req",  32'(int_req),  32'(m_state == M_REQ));
        chk("int_prio", 32'(int_prio), 32'(m_wprio));
        chk("int_vec",  32'(int_vec),  32'(m_vec));
        chk("pending",  32'(pending),  32'(m_pending()));
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        logic [NS-1:0] e, nl;
        int best, bp, clr;
        e = m_elig();
        best = -1;
        bp = 0;
        for (int k = 0; k < NS; k++) begin
            if (e[k] && int'(m_prio[k]) > bp) begin
                best = k;
                bp = int'(m_prio[k]);
            end
        end
        clr = -1;
        case (m_state)
            M_IDLE: if (best >= 0) begin
                m_state = M_REQ;
                m_win   = best;
                m_wprio = 3'(bp);
                m_vec   = 8'(8'h80 + best);
            end
            M_REQ: begin
                if (int_ack) begin
                    m_state = M_HOLD;
                    clr = m_win;
                end else if (!e[m_win]) begin
                    m_state = M_IDLE;
                end
            end
            default: m_state = M_IDLE;
        endcase
        for (int k = 0; k < NS; k++)
            nl[k] = m_edge[k] && ((m_latch[k] && k != clr) || (irq[k] && !m_prev[k]));
        if (cfg_we && int'(cfg_idx) < NS) begin
            if (!cfg_edge) nl[cfg_idx[1:0]] = 1'b0;
            m_en[cfg_idx[1:0]]   = cfg_en;
            m_edge[cfg_idx[1:0]] = cfg_edge;
            m_prio[cfg_idx[1:0]] = cfg_prio;
        end
        m_latch = nl;
        m_prev  = irq;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic run_cycle();
        #1;
        check_model();
        model_step();
        @(negedge clk);
    endtask

    task automatic cfg(input int idx, input logic en, input logic edg, input int prio);
        cfg_we   = 1'b1;
        cfg_idx  = 4'(idx);
        cfg_en   = en;
        cfg_edge = edg;
        cfg_prio = 3'(prio);
        run_cycle();
        cfg_we   = 1'b0;
    endtask

    // Reset asserted between clock edges; the request must vanish without a clock.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("async_req_drop", 32'(int_req), 0);
        chk("rst_prio", 32'(int_prio), 0);
        chk("rst_vec", 32'(int_vec), 0);
        chk("rst_pending", 32'(pending), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req", 32'(int_req), 0);
        chk("reset_prio", 32'(int_prio), 0);
        chk("reset_vec", 32'(int_vec), 0);
        chk("reset_pending", 32'(pending), 0);
        model_reset();
        rst = 1'b1;

        // Level source offered one cycle after assertion, then ack -> HOLD.
        cfg(1, 1, 0, 4);
        cur_prio = 3'd2; irq = 4'b0010; run_cycle();
        chk("s035_req", 32'(int_req), 1);
        chk("s035_prio", 32'(int_prio), 4);
        chk("s035_vec", 32'(int_vec), 32'h81);
        int_ack = 1; run_cycle();
        chk("s035_hold", 32'(int_req), 0);
        int_ack = 0; irq = 0; run_cycle();
        chk("s035_idle", 32'(int_req), 0);

        // Equal priority tie, then masking by cur_prio.
        cur_prio = 0;
        cfg(0, 1, 0, 5);
        cfg(3, 1, 0, 5);
        irq = 4'b1001; run_cycle();
        chk("s036_tie_vec", 32'(int_vec), 32'h80);
        chk("s036_tie_prio", 32'(int_prio), 5);
        int_ack = 1; irq = 4'b1000; run_cycle();
        int_ack = 0; cur_prio = 3'd5; run_cycle(); run_cycle();
        chk("s036_masked", 32'(int_req), 0);
        cur_prio = 0; run_cycle();
        chk("s036_src3_req", 32'(int_req), 1);
        chk("s036_src3_vec", 32'(int_vec), 32'h83);
        int_ack = 1; irq = 0; run_cycle();
        int_ack = 0; run_cycle();

        // Edge source latches a one-cycle pulse until ack.
        cfg(2, 1, 1, 3);
        irq = 4'b0100; run_cycle();
        chk("s037_pend_set", 32'(pending[2]), 1);
        chk("s037_latency", 32'(int_req), 0);
        irq = 0; run_cycle();
        chk("s037_req", 32'(int_req), 1);
        chk("s037_vec", 32'(int_vec), 32'h82);
        run_cycle(); run_cycle();
        chk("s037_pend_hold", 32'(pending[2]), 1);
        int_ack = 1; run_cycle();
        chk("s037_pend_clr", 32'(pending[2]), 0);
        int_ack = 0; run_cycle();
        irq = 4'b0100; run_cycle();
        irq = 0; run_cycle();
        chk("s037_req2", 32'(int_req), 1);
        int_ack = 1; irq = 4'b0100; run_cycle();
        chk("s037_set_wins", 32'(pending[2]), 1);
        int_ack = 0; irq = 0; run_cycle(); run_cycle();
        chk("s037_reoffer", 32'(int_vec), 32'h82);
        chk("s037_reoffer_req", 32'(int_req), 1);
        int_ack = 1; run_cycle();
        int_ack = 0; run_cycle();
        chk("s037_pend_final", 32'(pending[2]), 0);

        // Withdraw on cur_prio rise; same cycle with ack -> ack wins.
        cur_prio = 3'd2; irq = 4'b0010; run_cycle();
        chk("s038_req", 32'(int_req), 1);
        cur_prio = 3'd4; run_cycle();
        chk("s038_withdraw", 32'(int_req), 0);
        cur_prio = 3'd2; run_cycle();
        chk("s038_reoffer", 32'(int_req), 1);
        cur_prio = 3'd4; int_ack = 1; run_cycle();
        chk("s038_ack_hold", 32'(int_req), 0);
        int_ack = 0; cur_prio = 3'd2; run_cycle();
        chk("s038_hold_gap", 32'(int_req), 0);
        run_cycle();
        chk("s038_after_hold", 32'(int_req), 1);
        int_ack = 1; irq = 0; run_cycle();
        int_ack = 0; run_cycle();

        // No preemption of an outstanding lower-priority request.
        cur_prio = 0;
        cfg(0, 1, 0, 2);
        cfg(3, 1, 0, 7);
        irq = 4'b0001; run_cycle();
        chk("s039_vec", 32'(int_vec), 32'h80);
        chk("s039_prio", 32'(int_prio), 2);
        irq = 4'b1001; run_cycle(); run_cycle();
        chk("s039_no_preempt", 32'(int_vec), 32'h80);
        int_ack = 1; irq = 4'b1000; run_cycle();
        int_ack = 0; run_cycle(); run_cycle();
        chk("s039_next_vec", 32'(int_vec), 32'h83);
        chk("s039_next_prio", 32'(int_prio), 7);
        int_ack = 1; irq = 0; run_cycle();
        int_ack = 0; run_cycle();

        // Reset in the middle of a request.
        irq = 4'b0001; run_cycle();
        chk("s040_req", 32'(int_req), 1);
        irq = 4'b1111;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            chk("s040_disabled", 32'(int_req), 0);
        end

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NS; k++)
                if ($urandom_range(0, 3) == 0) irq[k] = ~irq[k];
            cfg_we   = ($urandom_range(0, 11) == 0);
            cfg_idx  = 4'($urandom_range(0, 5));
            cfg_en   = ($urandom_range(0, 3) != 0);
            cfg_edge = 1'($urandom_range(0, 1));
            cfg_prio = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) cur_prio = 3'($urandom_range(0, 7));
            int_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else run_cycle();
        end
        cfg_we = 0;
        int_ack = 0;
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
